pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the pipelined CPU.
- Sits beside the decode stage and keeps a scoreboard of in-flight register writers, one slot per stage between decode and writeback.
- Each cycle it produces stall, bubble, flush and per-operand forwarding selects.
- Generalises the fixed three-stage pipeline to arbitrary depth and load latency, and adds saturating stall/flush counters.

---
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: scoreboard of in-flight writers, stall/bubble/flush and forward selects.
// Latency: all control outputs are combinational (zero cycles); scoreboard advances one slot per clock.
// Backpressure: stall holds PC and IF/ID; ex_redirect overrides stall and squashes the decode instruction.
//
// Ports:
//   clk, reset (async, active-low)
//   id_*        : decode-stage instruction (sources, destination, load flag, valid)
//   ex_redirect : slot-1 instruction redirects the PC
//   stall, bubble, flush_ifid : pipeline control
//   fwd_rs_sel, fwd_rt_sel    : 0 = register file, k = result held in scoreboard slot k
//   stall_count, flush_count  : saturating event counters
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 6,
  parameter int DEPTH       = 2,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16,
  parameter int SEL_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              stall,
  output logic              bubble,
  output logic              flush_ifid,
  output logic [SEL_W-1:0]  fwd_rs_sel,
  output logic [SEL_W-1:0]  fwd_rt_sel,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  // Slot k describes the instruction k stages past decode (1 = EX, DEPTH = WB).
  logic [DEPTH:1]    slot_vld;
  logic [DEPTH:1]    slot_wr;
  logic [DEPTH:1]    slot_ld;
  logic [REG_AW-1:0] slot_rd [1:DEPTH];
  logic [DEPTH:1]    slot_rdy;

  logic rs_live, rt_live;
  logic rs_haz, rt_haz;

  // A load result only becomes forwardable once it has travelled LOAD_LAT stages past EX.
  always_comb begin
    slot_rdy = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      slot_rdy[k] = !slot_ld[k] || (k >= 1 + LOAD_LAT);
    end
  end

  // Register 0 is hard-wired, so reading it never depends on an in-flight writer.
  assign rs_live = id_rs_used && !((ZERO_REG_EN != 0) && (id_rs == '0));
  assign rt_live = id_rt_used && !((ZERO_REG_EN != 0) && (id_rt == '0));

  // Scan oldest to youngest so the youngest matching slot is the one left standing.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    rs_haz     = 1'b0;
    rt_haz     = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (rs_live && slot_vld[k] && slot_wr[k] && (slot_rd[k] == id_rs)) begin
        fwd_rs_sel = slot_rdy[k] ? SEL_W'(k) : '0;
        rs_haz     = !slot_rdy[k];
      end
      if (rt_live && slot_vld[k] && slot_wr[k] && (slot_rd[k] == id_rt)) begin
        fwd_rt_sel = slot_rdy[k] ? SEL_W'(k) : '0;
        rt_haz     = !slot_rdy[k];
      end
    end
  end

  // Redirect gating by reset keeps every control output quiet while reset is held,
  // since ex_redirect is a raw input.
  assign flush_ifid = reset && ex_redirect;
  assign stall      = reset && id_valid && (rs_haz || rt_haz) && !ex_redirect;
  assign bubble     = stall || flush_ifid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_vld <= '0;
      slot_wr  <= '0;
      slot_ld  <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        slot_rd[k] <= '0;
      end
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        slot_vld[k] <= slot_vld[k-1];
        slot_wr[k]  <= slot_wr[k-1];
        slot_ld[k]  <= slot_ld[k-1];
        slot_rd[k]  <= slot_rd[k-1];
      end
      // A stalled or squashed decode instruction leaves a hole behind it.
      slot_vld[1] <= id_valid && !bubble;
      slot_wr[1]  <= id_wr_en;
      slot_ld[1]  <= id_is_load;
      slot_rd[1]  <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
      if (flush_ifid && (flush_count != {CNT_W{1'b1}})) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int REG_AW      = 6;
  localparam int DEPTH       = 2;
  localparam int LOAD_LAT    = 1;
  localparam int ZERO_REG_EN = 1;
  localparam int CNT_W       = 4;
  localparam int SEL_W       = $clog2(DEPTH + 1);
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, ex_redirect;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              stall, bubble, flush_ifid;
  logic [SEL_W-1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [CNT_W-1:0]  stall_count, flush_count;

  pipe_hazard_ctrl #(
    .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
    .ZERO_REG_EN(ZERO_REG_EN), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect),
    .stall(stall), .bubble(bubble), .flush_ifid(flush_ifid),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a queue of in-flight instructions, index 0 = one stage past decode.
  typedef struct {
    bit       vld;
    bit       wr;
    bit       ld;
    int       rd;
  } entry_t;

  entry_t pipe[$];
  int     m_stall_cnt, m_flush_cnt;

  function automatic void model_reset();
    entry_t e;
    e = '{vld: 0, wr: 0, ld: 0, rd: 0};
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endfunction

  // Youngest in-flight writer of r decides; a load too young to forward is a hazard.
  function automatic void op_eval(input int r, input bit used, output int sel, output bit haz);
    sel = 0;
    haz = 0;
    if (!used || (ZERO_REG_EN != 0 && r == 0)) return;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe[i].vld && pipe[i].wr && pipe[i].rd == r) begin
        if (!pipe[i].ld || (i + 1) >= 1 + LOAD_LAT) sel = i + 1;
        else haz = 1;
        return;
      end
    end
  endfunction

  // Called at the negative edge: compare DUT with the model, then advance the model across the next posedge.
  task automatic model_step(input string tag);
    int     rs_sel, rt_sel;
    bit     rs_haz, rt_haz, e_stall, e_bub;
    entry_t e;
    op_eval(int'(id_rs), id_rs_used, rs_sel, rs_haz);
    op_eval(int'(id_rt), id_rt_used, rt_sel, rt_haz);
    e_stall = id_valid && (rs_haz || rt_haz) && !ex_redirect;
    e_bub   = e_stall || ex_redirect;
    chk({tag, " stall"},  int'(stall),       int'(e_stall));
    chk({tag, " bubble"}, int'(bubble),      int'(e_bub));
    chk({tag, " flush"},  int'(flush_ifid),  int'(ex_redirect));
    chk({tag, " rs_sel"}, int'(fwd_rs_sel),  rs_sel);
    chk({tag, " rt_sel"}, int'(fwd_rt_sel),  rt_sel);
    chk({tag, " stall_count"}, int'(stall_count), m_stall_cnt);
    chk({tag, " flush_count"}, int'(flush_count), m_flush_cnt);
    @(posedge clk);
    e = '{vld: id_valid && !e_bub, wr: id_wr_en, ld: id_is_load, rd: int'(id_rd)};
    void'(pipe.pop_back());
    pipe.push_front(e);
    if (e_stall && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if (ex_redirect && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    #1;
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                       input bit wr, input int rd, input bit ld, input bit redir);
    id_valid    = v;
    id_rs       = REG_AW'(rs);
    id_rt       = REG_AW'(rt);
    id_rs_used  = rsu;
    id_rt_used  = rtu;
    id_wr_en    = wr;
    id_rd       = REG_AW'(rd);
    id_is_load  = ld;
    ex_redirect = redir;
  endtask

  typedef struct {
    bit v; int rs; int rt; bit rsu; bit rtu; bit wr; int rd; bit ld; bit redir;
    int e_stall; int e_bub; int e_flush; int e_rs; int e_rt;
  } vec_t;

  function automatic vec_t mk(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                              input bit wr, input int rd, input bit ld, input bit redir,
                              input int es, input int eb, input int ef, input int ers, input int ert);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.rsu = rsu; t.rtu = rtu; t.wr = wr; t.rd = rd; t.ld = ld;
    t.redir = redir; t.e_stall = es; t.e_bub = eb; t.e_flush = ef; t.e_rs = ers; t.e_rt = ert;
    return t;
  endfunction

  vec_t tbl[20];

  initial begin
    //            v  rs rt rsu rtu wr rd ld rdr | stall bub flush rs rt
    tbl[0]  = mk(1, 0, 0, 0, 0, 1, 5, 0, 0,   0, 0, 0, 0, 0); // ALU write r5
    tbl[1]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0); // rs=5 from EX
    tbl[2]  = mk(1, 0, 5, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 2); // rt=5 from WB
    tbl[3]  = mk(1, 0, 0, 0, 0, 1, 7, 1, 0,   0, 0, 0, 0, 0); // load r7
    tbl[4]  = mk(1, 0, 7, 0, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0); // load-use stall
    tbl[5]  = mk(1, 0, 7, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 2); // retry forwards from WB
    tbl[6]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0,   0, 0, 0, 0, 0); // write r3
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0,   0, 0, 0, 0, 0); // write r3 again
    tbl[8]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0); // youngest wins
    tbl[9]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0); // write r0
    tbl[10] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0); // r0 never forwards
    tbl[11] = mk(1, 0, 0, 0, 0, 1, 9, 1, 0,   0, 0, 0, 0, 0); // load r9
    tbl[12] = mk(1, 0, 9, 0, 1, 1, 9, 0, 1,   0, 1, 1, 0, 0); // consumer squashed by redirect
    tbl[13] = mk(0, 0, 9, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 2); // EX slot empty, load in WB
    tbl[14] = mk(1, 0, 0, 0, 0, 1, 4, 1, 0,   0, 0, 0, 0, 0); // load r4
    tbl[15] = mk(0, 4, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0); // hazard but no valid instr
    tbl[16] = mk(1, 4, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 2, 0); // load now in WB
    tbl[17] = mk(1, 0, 0, 0, 0, 1, 6, 1, 0,   0, 0, 0, 0, 0); // load r6
    tbl[18] = mk(1, 6, 6, 1, 1, 0, 0, 0, 0,   1, 1, 0, 0, 0); // dual hazard, single stall
    tbl[19] = mk(1, 6, 6, 1, 1, 0, 0, 0, 0,   0, 0, 0, 2, 2); // both forward from WB

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", int'(stall), 0);
    chk("reset stall_count", int'(stall_count), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed table from an empty scoreboard.
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].rsu, tbl[i].rtu,
            tbl[i].wr, tbl[i].rd, tbl[i].ld, tbl[i].redir);
      @(negedge clk);
      chk($sformatf("vec%0d stall", i),  int'(stall),      tbl[i].e_stall);
      chk($sformatf("vec%0d bubble", i), int'(bubble),     tbl[i].e_bub);
      chk($sformatf("vec%0d flush", i),  int'(flush_ifid), tbl[i].e_flush);
      chk($sformatf("vec%0d rs_sel", i), int'(fwd_rs_sel), tbl[i].e_rs);
      chk($sformatf("vec%0d rt_sel", i), int'(fwd_rt_sel), tbl[i].e_rt);
      model_step($sformatf("vec%0d model", i));
    end
    @(negedge clk);
    chk("table stall_count", int'(stall_count), 2);
    chk("table flush_count", int'(flush_count), 1);

    // Mid-stream asynchronous reset with an active forward and redirect on the inputs.
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0);
    model_step("pre-reset write");
    drive(1, 5, 5, 1, 1, 0, 0, 0, 1);
    #1;
    chk("pre-reset rs_sel", int'(fwd_rs_sel), 1);
    #1;
    reset = 1'b0;
    #1;
    chk("async reset stall", int'(stall), 0);
    chk("async reset bubble", int'(bubble), 0);
    chk("async reset flush", int'(flush_ifid), 0);
    chk("async reset rs_sel", int'(fwd_rs_sel), 0);
    chk("async reset rt_sel", int'(fwd_rt_sel), 0);
    chk("async reset stall_count", int'(stall_count), 0);
    chk("async reset flush_count", int'(flush_count), 0);
    @(posedge clk);
    @(negedge clk);
    chk("held reset flush", int'(flush_ifid), 0);
    chk("held reset rs_sel", int'(fwd_rs_sel), 0);
    reset = 1'b1;
    #1;
    chk("release stall", int'(stall), 0);
    chk("release rs_sel", int'(fwd_rs_sel), 0);
    chk("release flush_count", int'(flush_count), 0);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Repeated load-use hazards drive the stall counter into saturation.
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      drive(1, 0, 0, 0, 0, 1, 7, 1, 0);
      @(negedge clk);
      model_step("sat load");
      drive(1, 0, 7, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      model_step("sat use");
    end
    @(negedge clk);
    chk("stall_count saturated", int'(stall_count), CNT_MAX);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      @(negedge clk);
      model_step($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
